// File: rtl/reg_file_wb.sv
// Dual-writeback, six-read-port 128x128 register file with collision flag and saturating write counter.
// Optional macro RF_BYPASS_EN forwards same-cycle write data to the read ports (odd pipe has priority).
module reg_file_wb #(
    parameter int NUM_REGS = 128,
    parameter int DATA_W   = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] rt_even_wb,
    input  logic [6:0]        rt_addr_even_wb,
    input  logic              reg_write_even_wb,
    input  logic [DATA_W-1:0] rt_odd_wb,
    input  logic [6:0]        rt_addr_odd_wb,
    input  logic              reg_write_odd_wb,
    input  logic [6:0]        ra_even_addr,
    input  logic [6:0]        rb_even_addr,
    input  logic [6:0]        rc_even_addr,
    input  logic [6:0]        ra_odd_addr,
    input  logic [6:0]        rb_odd_addr,
    input  logic [6:0]        rc_odd_addr,
    output logic [DATA_W-1:0] ra_even,
    output logic [DATA_W-1:0] rb_even,
    output logic [DATA_W-1:0] rc_even,
    output logic [DATA_W-1:0] ra_odd,
    output logic [DATA_W-1:0] rb_odd,
    output logic [DATA_W-1:0] rc_odd,
    output logic              wr_conflict,
    output logic [15:0]       wr_count
);

    logic [DATA_W-1:0] mem_q [NUM_REGS];
    logic [DATA_W-1:0] mem_d [NUM_REGS];
    logic [6:0]        rd_addr [6];
    logic [DATA_W-1:0] rd_data [6];
    logic              wr_conflict_q, wr_conflict_d;
    logic [15:0]       wr_count_q, wr_count_d;
    logic              same_addr;
    logic [1:0]        wr_inc;
    logic [16:0]       wr_sum;

    assign same_addr = reg_write_even_wb && reg_write_odd_wb
                       && (rt_addr_even_wb == rt_addr_odd_wb);

    // Odd write applied last so it overrides the even write on a collision.
    always_comb begin
        mem_d = mem_q;
        if (reg_write_even_wb) mem_d[rt_addr_even_wb] = rt_even_wb;
        if (reg_write_odd_wb)  mem_d[rt_addr_odd_wb]  = rt_odd_wb;
    end

    always_comb begin
        wr_conflict_d = same_addr;
        if (same_addr)
            wr_inc = 2'd1;
        else
            wr_inc = {1'b0, reg_write_even_wb} + {1'b0, reg_write_odd_wb};
        wr_sum     = {1'b0, wr_count_q} + {15'b0, wr_inc};
        wr_count_d = wr_sum[16] ? 16'hFFFF : wr_sum[15:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
            wr_conflict_q <= 1'b0;
            wr_count_q    <= '0;
        end else begin
            mem_q         <= mem_d;
            wr_conflict_q <= wr_conflict_d;
            wr_count_q    <= wr_count_d;
        end
    end

    assign rd_addr[0] = ra_even_addr;
    assign rd_addr[1] = rb_even_addr;
    assign rd_addr[2] = rc_even_addr;
    assign rd_addr[3] = ra_odd_addr;
    assign rd_addr[4] = rb_odd_addr;
    assign rd_addr[5] = rc_odd_addr;

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_rd
            logic [DATA_W-1:0] rd_d, rd_q;

            always_comb begin
                rd_d = mem_q[rd_addr[gi]];
`ifdef RF_BYPASS_EN
                if (reg_write_even_wb && (rt_addr_even_wb == rd_addr[gi])) rd_d = rt_even_wb;
                if (reg_write_odd_wb  && (rt_addr_odd_wb  == rd_addr[gi])) rd_d = rt_odd_wb;
`endif
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) rd_q <= '0;
                else        rd_q <= rd_d;
            end

            assign rd_data[gi] = rd_q;
        end
    endgenerate

    assign ra_even     = rd_data[0];
    assign rb_even     = rd_data[1];
    assign rc_even     = rd_data[2];
    assign ra_odd      = rd_data[3];
    assign rb_odd      = rd_data[4];
    assign rc_odd      = rd_data[5];
    assign wr_conflict = wr_conflict_q;
    assign wr_count    = wr_count_q;

endmodule

// File: tb/tb_reg_file_wb.sv
// Randomized bench for reg_file_wb: array-based reference model checked every cycle, plus literal scenario checks.
module tb_reg_file_wb;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] rt_even_wb, rt_odd_wb;
    logic [6:0]   rt_addr_even_wb, rt_addr_odd_wb;
    logic         reg_write_even_wb, reg_write_odd_wb;
    logic [6:0]   rd_a [6];
    logic [127:0] ra_even, rb_even, rc_even, ra_odd, rb_odd, rc_odd;
    logic         wr_conflict;
    logic [15:0]  wr_count;
    logic [127:0] dout [6];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    reg_file_wb dut (
        .clk               (clk),
        .reset             (reset),
        .rt_even_wb        (rt_even_wb),
        .rt_addr_even_wb   (rt_addr_even_wb),
        .reg_write_even_wb (reg_write_even_wb),
        .rt_odd_wb         (rt_odd_wb),
        .rt_addr_odd_wb    (rt_addr_odd_wb),
        .reg_write_odd_wb  (reg_write_odd_wb),
        .ra_even_addr      (rd_a[0]),
        .rb_even_addr      (rd_a[1]),
        .rc_even_addr      (rd_a[2]),
        .ra_odd_addr       (rd_a[3]),
        .rb_odd_addr       (rd_a[4]),
        .rc_odd_addr       (rd_a[5]),
        .ra_even           (ra_even),
        .rb_even           (rb_even),
        .rc_even           (rc_even),
        .ra_odd            (ra_odd),
        .rb_odd            (rb_odd),
        .rc_odd            (rc_odd),
        .wr_conflict       (wr_conflict),
        .wr_count          (wr_count)
    );

    assign dout[0] = ra_even;
    assign dout[1] = rb_even;
    assign dout[2] = rc_even;
    assign dout[3] = ra_odd;
    assign dout[4] = rb_odd;
    assign dout[5] = rc_odd;

    // Reference model: architectural registers, expected read results and counters.
    logic [127:0] mdl [128];
    logic [127:0] exp_rd [6];
    logic         exp_conf;
    int           exp_cnt;

    function automatic logic [127:0] model_read(input logic [6:0] a);
        logic [127:0] v;
        v = mdl[a];
`ifdef RF_BYPASS_EN
        if (reg_write_even_wb && rt_addr_even_wb == a) v = rt_even_wb;
        if (reg_write_odd_wb && rt_addr_odd_wb == a)   v = rt_odd_wb;
`endif
        return v;
    endfunction

    function automatic int writes_this_cycle();
        if (reg_write_even_wb && reg_write_odd_wb && rt_addr_even_wb == rt_addr_odd_wb) return 1;
        return int'(reg_write_even_wb) + int'(reg_write_odd_wb);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 128; i++) mdl[i] <= '0;
            for (int p = 0; p < 6; p++) exp_rd[p] <= '0;
            exp_conf <= 1'b0;
            exp_cnt  <= 0;
        end else begin
            for (int p = 0; p < 6; p++) exp_rd[p] <= model_read(rd_a[p]);
            exp_conf <= reg_write_even_wb && reg_write_odd_wb && rt_addr_even_wb == rt_addr_odd_wb;
            exp_cnt  <= (exp_cnt + writes_this_cycle() > 65535) ? 65535 : exp_cnt + writes_this_cycle();
            if (reg_write_even_wb) mdl[rt_addr_even_wb] <= rt_even_wb;
            if (reg_write_odd_wb)  mdl[rt_addr_odd_wb]  <= rt_odd_wb;
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_chk++;
        if (act !== req)
            $display("FAIL %s actual=%h required=%h", name, act, req);
        else
            n_pass++;
    endtask

    always @(negedge clk) begin
        for (int p = 0; p < 6; p++) chk($sformatf("model_rd%0d", p), dout[p], exp_rd[p]);
        chk("model_wr_conflict", {127'b0, wr_conflict}, {127'b0, exp_conf});
        chk("model_wr_count", {112'b0, wr_count}, 128'(exp_cnt));
    end

    task automatic drive(input logic we_e, input logic [6:0] ae, input logic [127:0] de,
                         input logic we_o, input logic [6:0] ao, input logic [127:0] dd);
        reg_write_even_wb = we_e;
        rt_addr_even_wb   = ae;
        rt_even_wb        = de;
        reg_write_odd_wb  = we_o;
        rt_addr_odd_wb    = ao;
        rt_odd_wb         = dd;
        @(negedge clk);
    endtask

    task automatic set_reads(input logic [6:0] a);
        for (int p = 0; p < 6; p++) rd_a[p] = a;
    endtask

    initial begin
        logic [127:0] a5, five_a, beef, rnd_e, rnd_o;
        int guard;
        a5     = {16{8'hA5}};
        five_a = {16{8'h5A}};
        beef   = {{15{8'hDE}}, 8'hEF};
        beef   = {32'hDEADBEEF, 64'h0, 32'hDEADBEEF};

        reset = 1'b0;
        set_reads(7'd5);
        // Writes during reset must be discarded.
        drive(1'b1, 7'd5, 128'h1234, 1'b1, 7'd5, 128'h5678);
        drive(1'b1, 7'd5, 128'h1234, 1'b0, 7'd0, 128'h0);
        chk("reset_wr_count", {112'b0, wr_count}, 128'h0);
        reset = 1'b1;
        drive(1'b0, 7'd0, 128'h0, 1'b0, 7'd0, 128'h0);
        chk("reset_r5", ra_even, 128'h0);
        chk("reset_wr_count_after", {112'b0, wr_count}, 128'h0);
        chk("reset_wr_conflict", {127'b0, wr_conflict}, 128'h0);

        set_reads(7'd0);
        drive(1'b1, 7'd3, 128'h1, 1'b0, 7'd0, 128'h0);
        rd_a[3] = 7'd3;
        drive(1'b0, 7'd0, 128'h0, 1'b0, 7'd0, 128'h0);
        chk("basic_ra_odd", ra_odd, 128'h1);
        chk("basic_wr_count", {112'b0, wr_count}, 128'h1);

        set_reads(7'd0);
        drive(1'b1, 7'd7, a5, 1'b1, 7'd7, five_a);
        chk("collide_conflict_hi", {127'b0, wr_conflict}, 128'h1);
        chk("collide_wr_count", {112'b0, wr_count}, 128'h2);
        rd_a[0] = 7'd7;
        drive(1'b0, 7'd0, 128'h0, 1'b0, 7'd0, 128'h0);
        chk("collide_conflict_lo", {127'b0, wr_conflict}, 128'h0);
        chk("collide_r7", ra_even, five_a);

        set_reads(7'd0);
        rd_a[1] = 7'd9;
        drive(1'b1, 7'd9, beef, 1'b0, 7'd0, 128'h0);
`ifdef RF_BYPASS_EN
        chk("bypass_rb_even", rb_even, beef);
`else
        chk("nobypass_rb_even", rb_even, 128'h0);
`endif
        drive(1'b0, 7'd0, 128'h0, 1'b0, 7'd0, 128'h0);
        chk("after_write_rb_even", rb_even, beef);
        chk("reg0_readable_zero", ra_even, 128'h0);

        drive(1'b1, 7'd0, 128'hC0DE, 1'b0, 7'd0, 128'h0);
        set_reads(7'd0);
        drive(1'b0, 7'd0, 128'h0, 1'b0, 7'd0, 128'h0);
        chk("reg0_written", rc_odd, 128'hC0DE);
        chk("same_addr_ports", ra_even, 128'hC0DE);

        // Mid-operation asynchronous reset.
        set_reads(7'd10);
        drive(1'b1, 7'd10, 128'hFF, 1'b0, 7'd0, 128'h0);
        drive(1'b0, 7'd0, 128'h0, 1'b0, 7'd0, 128'h0);
        chk("midop_r10_before", ra_even, 128'hFF);
        reg_write_even_wb = 1'b1;
        rt_addr_even_wb   = 7'd10;
        rt_even_wb        = 128'hAB;
        #2 reset = 1'b0;
        #1;
        chk("midop_rd_zero", ra_odd, 128'h0);
        chk("midop_count_zero", {112'b0, wr_count}, 128'h0);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 7'd0, 128'h0, 1'b0, 7'd0, 128'h0);
        chk("midop_r10_after", rb_odd, 128'h0);

        // Random traffic on a narrow address window to provoke collisions and hazards.
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < 6; p++) rd_a[p] = 7'($urandom_range(0, 15));
            rnd_e = {$urandom, $urandom, $urandom, $urandom};
            rnd_o = {$urandom, $urandom, $urandom, $urandom};
            drive(1'($urandom), 7'($urandom_range(0, 15)), rnd_e,
                  1'($urandom), 7'($urandom_range(0, 15)), rnd_o);
        end

        // Saturation: bring the count to FFFE, then dual writes must stop at FFFF.
        guard = 0;
        while (exp_cnt < 65534 && guard < 70000) begin
            set_reads(7'($urandom_range(0, 3)));
            if (exp_cnt <= 65532)
                drive(1'b1, 7'd1, 128'(guard), 1'b1, 7'd2, 128'(guard + 1));
            else
                drive(1'b1, 7'd1, 128'(guard), 1'b0, 7'd0, 128'h0);
            guard++;
        end
        chk("sat_preload", {112'b0, wr_count}, 128'hFFFE);
        drive(1'b1, 7'd1, 128'h11, 1'b1, 7'd2, 128'h22);
        chk("sat_reach", {112'b0, wr_count}, 128'hFFFF);
        drive(1'b1, 7'd1, 128'h33, 1'b1, 7'd2, 128'h44);
        chk("sat_hold", {112'b0, wr_count}, 128'hFFFF);
        set_reads(7'd2);
        drive(1'b0, 7'd0, 128'h0, 1'b0, 7'd0, 128'h0);
        chk("sat_r2", ra_even, 128'h44);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
